puf_challenge_sequencer: RTL

Sequences challenges into the 4-bit arbiter PUF array and collects a majority-voted response per challenge. On start it walks CNT consecutive challenges beginning at a base value. For each one it holds the challenge for a settle window, then samples the PUF response NUM_VOTES times. The voted result is presented on a valid/ready output port for downstream logic (LED display, UART dump, enrollment store). It sits between the switch/host front end and the bit-arbiter instances, replacing direct SW-to-PUF wiring.

---
 rtl/puf_challenge_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
// Walks a run of consecutive challenges into the arbiter PUF array. Each
// challenge is held for a settle window and then sampled NUM_VOTES times.
// The per-bit majority vote is offered on a valid/ready port together with
// the index of the challenge that produced it.
module puf_challenge_sequencer #(
    parameter int CHAL_W        = 16,
    parameter int RESP_W        = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int NUM_VOTES     = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CHAL_W-1:0] base_challenge,
    input  logic [7:0]        count,
    output logic [CHAL_W-1:0] challenge,
    input  logic [RESP_W-1:0] puf_response,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_data,
    output logic [7:0]        resp_index,
    output logic              done
);

    // One counter times both the settle window and the sampling window.
    localparam int CYC_MAX = (SETTLE_CYCLES > NUM_VOTES) ? SETTLE_CYCLES : NUM_VOTES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int VOTE_W  = $clog2(NUM_VOTES + 1);

    localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0]  VOTES_LAST  = CYC_W'(NUM_VOTES - 1);
    localparam logic [VOTE_W-1:0] VOTE_HALF   = VOTE_W'(NUM_VOTES / 2);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        OUTPUT,
        FINISH
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CYC_W-1:0]    cyc_cnt;
    logic [7:0]          cnt_q;
    logic [7:0]          idx;
    logic [RESP_W-1:0]   sync_meta;
    logic [RESP_W-1:0]   sync_resp;
    logic [VOTE_W-1:0]   ones [RESP_W];
    logic [RESP_W-1:0]   vote;
    logic                settle_done;
    logic                votes_done;
    logic                last_chal;

    assign settle_done = (cyc_cnt == SETTLE_LAST);
    assign votes_done  = (cyc_cnt == VOTES_LAST);
    assign last_chal   = (idx == cnt_q - 8'd1);

    assign busy       = (state == APPLY) || (state == SAMPLE) || (state == OUTPUT);
    assign done       = (state == FINISH);
    assign resp_index = idx;

    // Two-flop synchroniser: the PUF response is asynchronous to CLK.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value; blocking here would collapse the two
        // synchroniser stages into one.
        if (RST) begin
            sync_meta <= '0;
            sync_resp <= '0;
        end else begin
            sync_meta <= puf_response;
            sync_resp <= sync_meta;
        end
    end

    // Per-bit majority: a bit is 1 when strictly more than half the samples were 1.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        vote = '0;
        for (int b = 0; b < RESP_W; b++) begin
            vote[b] = (ones[b] > VOTE_HALF);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (count == 8'd0) ? FINISH : APPLY;
                end
            end
            APPLY: begin
                if (settle_done) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (votes_done) begin
                    state_nx = OUTPUT;
                end
            end
            OUTPUT: begin
                if (resp_valid && resp_ready) begin
                    state_nx = last_chal ? FINISH : APPLY;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: run capture, window timing, vote accumulation, response handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            challenge  <= '0;
            cnt_q      <= '0;
            idx        <= '0;
            cyc_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            // NOTE: the vote counters are a handful of flops, not a RAM, so
            // they are reset like any other register and an aborted run
            // cannot leak partial tallies into the next one.
            for (int b = 0; b < RESP_W; b++) begin
                ones[b] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != 8'd0)) begin
                        challenge <= base_challenge;
                        cnt_q     <= count;
                        idx       <= '0;
                        cyc_cnt   <= '0;
                        for (int b = 0; b < RESP_W; b++) begin
                            ones[b] <= '0;
                        end
                    end
                end
                APPLY: begin
                    cyc_cnt <= settle_done ? '0 : cyc_cnt + CYC_W'(1);
                end
                SAMPLE: begin
                    cyc_cnt <= votes_done ? '0 : cyc_cnt + CYC_W'(1);
                    for (int b = 0; b < RESP_W; b++) begin
                        ones[b] <= ones[b] + VOTE_W'(sync_resp[b]);
                    end
                end
                OUTPUT: begin
                    if (!resp_valid) begin
                        // Tallies are final; register the vote and offer it.
                        resp_valid <= 1'b1;
                        resp_data  <= vote;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        for (int b = 0; b < RESP_W; b++) begin
                            ones[b] <= '0;
                        end
                        if (!last_chal) begin
                            idx       <= idx + 8'd1;
                            challenge <= challenge + CHAL_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
